johnson_counter: RTL and testbench
==================================

Name: johnson_counter

Overview:
- Parameterisable self-correcting Johnson (twisted-ring) counter with one clock and an asynchronous reset.
- Free-runs through 2*BITS states. Provides the raw ring state plus decoded outputs: phase index, one-hot phase, terminal-count and illegal-state flag.
- Intended as a low-glitch sequencer and phase generator for downstream control logic.

Parameters:
- BITS, 4, ring width in flip-flops. Legal range is BITS >= 2. Sequence length is 2*BITS.
- PW, $clog2(2*BITS), width of the phase index. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-high reset. Counter is held in reset while reset_n = 1. The port name follows the codebase convention; the polarity is active-high regardless of the suffix.
- Q  output  BITS  registered Johnson ring state
- phase  output  PW  combinational index 0..2*BITS-1 of the current Q
- phase_oh  output  2*BITS  combinational one-hot of phase. All zeros when illegal = 1.
- tc  output  1  combinational terminal count. High when phase = 2*BITS-1, i.e. the next edge returns Q to 0.
- illegal  output  1  combinational. High when Q is not one of the 2*BITS valid Johnson codes.

Behaviour:
- Reset:
  - Asynchronous on reset_n rising to 1: Q = 0 immediately, independent of clk.
  - While in reset: phase = 0, phase_oh = 1 (bit 0 set), tc = 0, illegal = 0.
- Release: first rising clk edge after reset_n returns to 0 advances the counter. There is no extra latency.
- Normal step, every rising edge when not illegal: Q <= {Q[BITS-2:0], ~Q[BITS-1]}. This shifts left and inserts the inverted MSB at the LSB.
- Sequence for BITS = 4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000. Period is 8 clocks.
- Valid codes:
  - Phase k in 0..BITS: Q holds the k LSBs set and the rest clear.
  - Phase BITS+j in 1..BITS-1: Q holds the BITS-j MSBs set and the rest clear.
- Phase decode: phase follows the two rules above. Fully combinational from Q, with no added latency.
- Wrap-around:
  - tc = 1 only while Q = {1'b1, (BITS-1)'b0}.
  - Next edge gives Q = 0, phase = 0.
  - tc asserts exactly once per 2*BITS cycles.
- Self-correction:
  - Any non-Johnson Q (e.g. 0101 after an upset, or from simulation X-resolution) sets illegal = 1 and forces phase = 0.
  - The next rising edge loads Q = 0, so recovery takes 1 cycle.
  - Then the normal sequence resumes.
- Reset mid-sequence: Q clears immediately, and counting restarts from phase 0 after release.
- Simultaneous reset assertion and clk edge: reset wins, Q = 0.
- Glitch property: exactly one bit of Q changes per legal step.
- No X may propagate after reset. All outputs are defined for every Q value.

Test Plan:
- Reset (BITS = 4): assert reset_n = 1 for 2 ns asynchronously mid-cycle, then 0 -> Q = 0000 immediately, phase = 0, phase_oh = 00000001, tc = 0, illegal = 0.
- Free-run (BITS = 4, 10 ns clock): 16 edges -> Q steps 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then repeats. phase goes 0..7 and repeats, one bit of Q changes per edge.
- Terminal count: -> tc = 1 only while Q = 1000, i.e. every 8th cycle. The following edge gives Q = 0000.
- Mid-run reset: assert reset_n while Q = 0111 -> Q = 0000 without waiting for clk. After release, the next edge gives Q = 0001.
- Illegal recovery: force Q = 0101, then release -> illegal = 1, phase = 0, phase_oh = 0. Next edge gives Q = 0000, illegal = 0.
- Width sweep: BITS = 2 gives period 4 (00, 01, 11, 10). BITS = 8 gives period 16. In both, tc fires once per period and every reachable Q gives illegal = 0.

Source files
------------

// File: rtl/johnson_counter.sv
// Self-correcting Johnson (twisted-ring) counter with a decoded phase index,
// a one-hot phase, a terminal-count flag and an illegal-state flag.
module johnson_counter #(
  parameter int  BITS = 4,
  localparam int PW   = $clog2(2 * BITS)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [BITS-1:0]     Q,
  output logic [PW-1:0]       phase,
  output logic [2*BITS-1:0]   phase_oh,
  output logic                tc,
  output logic                illegal
);

  logic [BITS-1:0] q_q;
  logic [BITS-1:0] q_d;

  // Valid code for phase k: k LSBs set for k <= BITS, otherwise the
  // (2*BITS - k) MSBs set.
  function automatic logic [BITS-1:0] johnson_code(input int k);
    logic [BITS-1:0] ones;
    ones = '1;
    if (k <= BITS) return ones >> (BITS - k);
    else           return ones << (k - BITS);
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // conditional update, so no path leaves it unassigned and no latch appears.
  always_comb begin
    phase    = '0;
    phase_oh = '0;
    illegal  = 1'b1;
    for (int k = 0; k < 2 * BITS; k++) begin
      if (q_q == johnson_code(k)) begin
        phase       = PW'(k);
        phase_oh[k] = 1'b1;
        illegal     = 1'b0;
      end
    end
  end

  assign tc = phase_oh[2*BITS-1];
  assign Q  = q_q;

  // Any non-Johnson pattern is flushed to the all-zero code in one cycle.
  always_comb begin
    q_d = {q_q[BITS-2:0], ~q_q[BITS-1]};
    if (illegal) q_d = '0;
  end

  // NOTE: the state register uses non-blocking assignments so every reader
  // on this edge sees the pre-edge value.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) q_q <= '0;
    else         q_q <= q_d;
  end

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter: a phase-based reference model
// compared every cycle for BITS = 4, 2 and 8, plus directed literal checks.
module tb_johnson_counter;

  logic clk;
  logic reset_n;

  logic [3:0]  q4;  logic [2:0] ph4; logic [7:0]  oh4; logic tc4; logic ill4;
  logic [1:0]  q2;  logic [1:0] ph2; logic [3:0]  oh2; logic tc2; logic ill2;
  logic [7:0]  q8;  logic [3:0] ph8; logic [15:0] oh8; logic tc8; logic ill8;

  johnson_counter #(.BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .Q(q4), .phase(ph4), .phase_oh(oh4), .tc(tc4), .illegal(ill4));
  johnson_counter #(.BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .Q(q2), .phase(ph2), .phase_oh(oh2), .tc(tc2), .illegal(ill2));
  johnson_counter #(.BITS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .Q(q8), .phase(ph8), .phase_oh(oh8), .tc(tc8), .illegal(ill8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain phase number per counter, advanced modulo 2*BITS.
  int p4 = 0, p2 = 0, p8 = 0;
  logic inj4 = 1'b0;   // stimulus has planted an illegal code in dut4
  logic chk_en = 1'b0;

  function automatic logic [31:0] exp_q(input int p, input int n);
    if (p <= n) return (32'd1 << p) - 32'd1;
    return ((32'd1 << n) - 32'd1) & ~((32'd1 << (p - n)) - 32'd1);
  endfunction

  always @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      p4 <= 0; p2 <= 0; p8 <= 0;
    end else begin
      p4 <= inj4 ? 0 : (p4 + 1) % 8;
      p2 <= (p2 + 1) % 4;
      p8 <= (p8 + 1) % 16;
    end
  end

  task automatic compare_dut(input string tag, input int p, input int n,
                             input logic [31:0] q, input logic [31:0] ph,
                             input logic [31:0] oh, input logic tc, input logic ill);
    check({tag, ".Q"},        q,          exp_q(p, n));
    check({tag, ".phase"},    ph,         32'(p));
    check({tag, ".phase_oh"}, oh,         32'd1 << p);
    check({tag, ".tc"},       32'(tc),    32'(p == 2 * n - 1));
    check({tag, ".illegal"},  32'(ill),   32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_dut("b4", p4, 4, 32'(q4), 32'(ph4), 32'(oh4), tc4, ill4);
      compare_dut("b2", p2, 2, 32'(q2), 32'(ph2), 32'(oh2), tc2, ill2);
      compare_dut("b8", p8, 8, 32'(q8), 32'(ph8), 32'(oh8), tc8, ill8);
    end
  end

  logic [3:0] seq4 [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  initial begin
    int n_tc4, n_tc2, n_tc8;
    logic [3:0] prev4;
    reset_n = 1'b0;

    // Asynchronous reset pulse mid-cycle, away from any clock edge.
    #2 reset_n = 1'b1;
    #1;
    check("rst.Q4",       32'(q4),   32'h0);
    check("rst.Q2",       32'(q2),   32'h0);
    check("rst.Q8",       32'(q8),   32'h0);
    check("rst.phase4",   32'(ph4),  32'h0);
    check("rst.oh4",      32'(oh4),  32'h01);
    check("rst.tc4",      32'(tc4),  32'h0);
    check("rst.illegal4", 32'(ill4), 32'h0);
    #1 reset_n = 1'b0;
    chk_en = 1'b1;

    // Free run: 16 edges with literal sequence, single-bit steps and tc counts.
    n_tc4 = 0; n_tc2 = 0; n_tc8 = 0;
    prev4 = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check("run.Q4",  32'(q4),  32'(seq4[i % 8]));
      check("run.tc4", 32'(tc4), 32'((i % 8) == 6));
      check("run.step4", 32'($countones(q4 ^ prev4)), 32'd1);
      prev4 = q4;
      n_tc4 += int'(tc4); n_tc2 += int'(tc2); n_tc8 += int'(tc8);
    end
    check("run.tc4_count", 32'(n_tc4), 32'd2);
    check("run.tc2_count", 32'(n_tc2), 32'd4);
    check("run.tc8_count", 32'(n_tc8), 32'd1);

    // Mid-run reset while dut4 sits at 0111.
    repeat (3) @(negedge clk);
    #1 check("mid.pre_Q4", 32'(q4), 32'h7);
    #1 reset_n = 1'b1;
    #1 check("mid.Q4", 32'(q4), 32'h0);
    #1 reset_n = 1'b0;
    @(negedge clk); #1;
    check("mid.after_Q4", 32'(q4), 32'h1);

    // Illegal-state recovery on dut4.
    repeat (2) @(negedge clk);
    #1 force dut4.q_q = 4'b0101;
    inj4 = 1'b1;
    #1;
    check("ill.flag",  32'(ill4), 32'h1);
    check("ill.phase", 32'(ph4),  32'h0);
    check("ill.oh",    32'(oh4),  32'h00);
    check("ill.tc",    32'(tc4),  32'h0);
    release dut4.q_q;
    @(posedge clk); #1;
    inj4 = 1'b0;
    check("ill.rec_Q4",   32'(q4),   32'h0);
    check("ill.rec_flag", 32'(ill4), 32'h0);
    @(posedge clk); #1;
    check("ill.resume_Q4", 32'(q4), 32'h1);

    // Further free run so the wider rings cover a full period under the model.
    repeat (20) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
